// File: rtl/par_serial_lane.sv
// par_serial_lane: one transmit lane. Buffers striped bytes in a small FIFO and
// serializes them MSB first at one bit per clk_8f cycle. After activation it
// sends INIT_COMS comma symbols, then sends data bytes, filling gaps with commas.
//
// Input handshake: a byte is taken on a rising clk_8f edge exactly when
// valid_in=1 and ready_out=1. When valid_in=1 and ready_out=0, the byte is
// dropped silently. ready_out depends only on the registered FIFO count, so a
// pop in the same cycle never frees a slot early.
module par_serial_lane #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  COM_SYM    = 8'hBC,
  parameter int unsigned INIT_COMS  = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       active,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_serial,
  output logic       sym_start,
  output logic       sym_is_data,
  output logic [1:0] dbg_state
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ICNT_W = $clog2(INIT_COMS + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [ICNT_W-1:0] INIT_LAST = ICNT_W'(INIT_COMS - 1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [ICNT_W-1:0] init_cnt_q, init_cnt_d;
  logic              sym_start_q, sym_start_d;
  logic              sym_is_data_q, sym_is_data_d;

  logic [7:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              boundary;
  logic [7:0]        fifo_head;

  // FIFO status decode from registered count (no pop bypass).
  always_comb begin
    ready_out  = (count_q < FULL_CNT);
    fifo_empty = (count_q == '0);
    push       = valid_in && ready_out;
    fifo_head  = fifo_mem_q[rd_ptr_q];
  end

  // FIFO pointer and count update; pointers wrap naturally (power-of-2 depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Lane FSM: symbol framing, comma insertion and FIFO pops at symbol boundaries.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    init_cnt_d    = init_cnt_q;
    sym_start_d   = 1'b0;
    sym_is_data_d = sym_is_data_q;
    pop           = 1'b0;
    boundary      = (bit_cnt_q == 3'd7);

    case (state_q)
      ST_OFF: begin
        shift_d       = 8'h00;
        sym_is_data_d = 1'b0;
        bit_cnt_d     = 3'd7;
        if (active) begin
          state_d     = ST_INIT;
          shift_d     = COM_SYM;
          bit_cnt_d   = 3'd0;
          init_cnt_d  = '0;
          sym_start_d = 1'b1;
        end
      end
      ST_INIT, ST_RUN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        shift_d   = {shift_q[6:0], 1'b0};
        if (boundary) begin
          if (!active) begin
            // Deassertion only takes effect once the current symbol is complete.
            state_d       = ST_OFF;
            shift_d       = 8'h00;
            sym_is_data_d = 1'b0;
            bit_cnt_d     = 3'd7;
            init_cnt_d    = '0;
          end else if ((state_q == ST_INIT) && (init_cnt_q != INIT_LAST)) begin
            init_cnt_d    = init_cnt_q + ICNT_W'(1);
            shift_d       = COM_SYM;
            sym_is_data_d = 1'b0;
            sym_start_d   = 1'b1;
          end else begin
            // Last init comma just ended, or a regular run boundary.
            state_d     = ST_RUN;
            init_cnt_d  = '0;
            sym_start_d = 1'b1;
            if (!fifo_empty) begin
              pop           = 1'b1;
              shift_d       = fifo_head;
              sym_is_data_d = 1'b1;
            end else begin
              shift_d       = COM_SYM;
              sym_is_data_d = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d       = ST_OFF;
        shift_d       = 8'h00;
        sym_is_data_d = 1'b0;
        bit_cnt_d     = 3'd7;
        init_cnt_d    = '0;
      end
    endcase
  end

  // Control and datapath registers; reset truncates any symbol in flight.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_OFF;
      bit_cnt_q     <= 3'd7;
      shift_q       <= 8'h00;
      init_cnt_q    <= '0;
      sym_start_q   <= 1'b0;
      sym_is_data_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      init_cnt_q    <= init_cnt_d;
      sym_start_q   <= sym_start_d;
      sym_is_data_q <= sym_is_data_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk_8f) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Registered outputs.
  always_comb begin
    data_serial = shift_q[7];
    sym_start   = sym_start_q;
    sym_is_data = sym_is_data_q;
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_par_serial_lane.sv
// Bench for par_serial_lane: a symbol-level reference model (byte queue,
// current symbol, bit position, commas still owed) predicts every output each cycle.
module tb_par_serial_lane;

  localparam int         DEPTH  = 4;
  localparam logic [7:0] COM    = 8'hBC;
  localparam int         N_INIT = 4;

  logic       clk_8f = 1'b0;
  logic       reset;
  logic       active;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_serial;
  logic       sym_start;
  logic       sym_is_data;
  logic [1:0] dbg_state;

  par_serial_lane #(
    .FIFO_DEPTH(DEPTH),
    .COM_SYM   (COM),
    .INIT_COMS (N_INIT)
  ) dut (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .active     (active),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_serial(data_serial),
    .sym_start  (sym_start),
    .sym_is_data(sym_is_data),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk_8f = ~clk_8f;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state.
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];      // bytes buffered in the lane, oldest first
  bit         m_on;          // lane is emitting symbols
  logic [7:0] m_sym;         // symbol currently on the wire
  int         m_pos;         // index of the bit on the wire, 0 = MSB
  bit         m_is_data;
  int         m_coms_left;   // init commas still owed, including the current one

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_on        = 1'b0;
    m_sym       = 8'h00;
    m_pos       = 0;
    m_is_data   = 1'b0;
    m_coms_left = 0;
  endfunction

  // One rising edge of the lane, described at symbol level.
  function automatic void model_edge(input bit a, input bit v, input logic [7:0] d);
    bit accept;
    accept = v && (exp_q.size() < DEPTH);
    if (!m_on) begin
      if (a) begin
        m_on        = 1'b1;
        m_sym       = COM;
        m_pos       = 0;
        m_is_data   = 1'b0;
        m_coms_left = N_INIT;
      end
    end else if (m_pos < 7) begin
      m_pos++;
    end else if (!a) begin
      m_on = 1'b0;
    end else begin
      m_pos = 0;
      if (m_coms_left > 0) m_coms_left--;
      if (m_coms_left > 0) begin
        m_sym     = COM;
        m_is_data = 1'b0;
      end else if (exp_q.size() > 0) begin
        m_sym     = exp_q.pop_front();
        m_is_data = 1'b1;
      end else begin
        m_sym     = COM;
        m_is_data = 1'b0;
      end
    end
    if (accept) exp_q.push_back(d);
  endfunction

  task automatic compare_outputs();
    logic exp_ds, exp_ss, exp_sd, exp_rdy;
    exp_ds  = m_on ? m_sym[7 - m_pos] : 1'b0;
    exp_ss  = m_on && (m_pos == 0);
    exp_sd  = m_on && m_is_data;
    exp_rdy = (exp_q.size() < DEPTH);
    check_eq("data_serial", {7'b0, data_serial}, {7'b0, exp_ds});
    check_eq("sym_start",   {7'b0, sym_start},   {7'b0, exp_ss});
    check_eq("sym_is_data", {7'b0, sym_is_data}, {7'b0, exp_sd});
    check_eq("ready_out",   {7'b0, ready_out},   {7'b0, exp_rdy});
  endtask

  // Driver: drive inputs after a falling edge, advance the model on the rising
  // edge, check on the next falling edge.
  task automatic cycle(input bit a, input bit v, input logic [7:0] d);
    active   = a;
    valid_in = v;
    data_in  = d;
    @(posedge clk_8f);
    model_edge(a, v, d);
    @(negedge clk_8f);
    compare_outputs();
  endtask

  task automatic apply_reset();
    @(negedge clk_8f);
    reset    = 1'b0;
    active   = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    model_reset();
    repeat (2) @(negedge clk_8f);
    compare_outputs();
    reset = 1'b1;
  endtask

  // Run idle active cycles until the model reaches a given bit position
  // (optionally inside a particular data symbol); bounded.
  task automatic wait_for(input int pos, input bit need_data, input logic [7:0] sym);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_on && (m_pos == pos) && (!need_data || (m_is_data && (m_sym == sym)))) begin
        found = 1'b1;
        break;
      end
      cycle(1'b1, 1'b0, 8'h00);
    end
    check_eq("wait_for", {7'b0, found}, 8'd1);
  endtask

  initial begin
    logic [7:0] cap;
    bit         act_r;

    reset    = 1'b1;
    active   = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    model_reset();

    // Reset state.
    apply_reset();
    check_eq("reset_ready", {7'b0, ready_out}, 8'd1);
    repeat (4) cycle(1'b0, 1'b0, 8'h00);

    // Activation with no data: four commas, then continuous commas.
    cap = 8'h00;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, 1'b0, 8'h00);
      cap = {cap[6:0], data_serial};
      if ((i % 8) == 7) check_eq("init_com", cap, 8'hBC);
    end
    repeat (24) cycle(1'b1, 1'b0, 8'h00);

    // Back-to-back bytes in RUN.
    cycle(1'b1, 1'b1, 8'hFF);
    cycle(1'b1, 1'b1, 8'hEE);
    repeat (40) cycle(1'b1, 1'b0, 8'h00);

    // Overfill while off: fifth byte dropped, four emerge after init.
    apply_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h10 + 8'(i));
    check_eq("full_ready", {7'b0, ready_out}, 8'd0);
    repeat (32 + 48) cycle(1'b1, 1'b0, 8'h00);

    // Push on the boundary edge into an empty FIFO: one comma first.
    wait_for(7, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h5A);
    repeat (24) cycle(1'b1, 1'b0, 8'h00);

    // Short active glitch mid-symbol is ignored.
    wait_for(2, 1'b0, 8'h00);
    repeat (3) cycle(1'b0, 1'b0, 8'h00);
    repeat (16) cycle(1'b1, 1'b0, 8'h00);

    // Drop active inside data symbol 3F; remaining bytes follow re-activation.
    cycle(1'b1, 1'b1, 8'h3F);
    cycle(1'b1, 1'b1, 8'h11);
    cycle(1'b1, 1'b1, 8'h22);
    wait_for(2, 1'b1, 8'h3F);
    repeat (20) cycle(1'b0, 1'b0, 8'h00);
    repeat (80) cycle(1'b1, 1'b0, 8'h00);

    // Asynchronous reset at bit 3 of a data symbol.
    cycle(1'b1, 1'b1, 8'hA5);
    cycle(1'b1, 1'b1, 8'hB6);
    wait_for(3, 1'b1, 8'hA5);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    compare_outputs();
    @(negedge clk_8f);
    compare_outputs();
    reset = 1'b1;
    repeat (6) cycle(1'b0, 1'b0, 8'h00);
    repeat (48) cycle(1'b1, 1'b0, 8'h00);

    // Randomized traffic with occasional activity changes.
    act_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) act_r = ~act_r;
      cycle(act_r, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
